// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares one single-port, 4-lane (4 x 8-bit) data memory between instruction
// fetch (IF) and the memory stage (DM). One access is in flight at a time.
// A half or word access that crosses a row boundary is split into two row
// beats. Write data is rotated onto the correct byte lanes and each beat gets
// its own byte enables. Read data is returned zero-extended; sign extension is
// done later, in writeback.
//
// Access sequence: IDLE -> B0 -> (split ? B1 : WT); B1 -> WT; WT -> RSP -> IDLE
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   if_req/if_addr  IF word-read request, held until if_gnt
//   if_gnt          IF request accepted this cycle (only in IDLE)
//   if_rvalid       one-cycle pulse, if_rdata holds the fetched word
//   dm_req/dm_we/dm_size/dm_addr/dm_wdata
//                   DM load/store request, held until dm_gnt
//                   size 00 byte, 01 half, 10/11 word; wdata right-justified
//   dm_gnt          DM request accepted this cycle (only in IDLE)
//   dm_rvalid       one-cycle pulse, load data valid / store complete
//   dm_rdata        zero-extended load data, held between responses
//   mem_en/mem_we   row access strobe and byte-enabled write strobe
//   mem_row         row address (byte address without the lane bits)
//   mem_be          byte-lane enables, bit i = lane i
//   mem_wdata       lane-aligned write data
//   mem_rdata       row read data, valid the cycle after a read beat
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_row,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int ROW_W = ADDR_W - 2;
  localparam int SW    = $clog2(MAX_STARVE + 1);

  typedef enum logic [2:0] {
    IDLE,
    B0,
    B1,
    WT,
    RSP
  } state_t;

  state_t state;
  state_t state_nx;

  // Consecutive IDLE cycles in which IF asked and lost
  logic [SW-1:0] starve;

  // Captured request of the access in flight
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_we;
  logic [1:0]        cap_size;
  logic              cap_dm;
  logic [31:0]       cap_wdata;

  // Low row of a split read, held until the high row arrives
  logic [31:0] lo_q;

  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;

  logic             idle;
  logic             starved;
  logic             if_win;
  logic [1:0]       off;
  logic [3:0]       mask;
  logic [7:0]       m8;
  logic             split;
  logic [ROW_W-1:0] row0;
  logic [ROW_W-1:0] row1;
  logic [31:0]      wdata_rot;
  logic [63:0]      rd64;
  logic [31:0]      rd_shift;
  logic [31:0]      rd_final;

  // Arbitration. DM normally wins; IF wins only once it has lost MAX_STARVE
  // times in a row. Grants are suppressed during reset so that no requester
  // drops its request believing it was accepted.
  always_comb begin
    starved = (starve == SW'(MAX_STARVE));
    idle    = (state == IDLE) && !rst;
    if_win  = if_req && (!dm_req || starved);
    if_gnt  = idle && if_win;
    dm_gnt  = idle && dm_req && !if_win;
  end

  // Access geometry derived from the captured request. m8 spans two rows;
  // any enable landing in the upper nibble means the access needs a second beat.
  always_comb begin
    off = cap_addr[1:0];
    case (cap_size)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    m8    = {4'b0000, mask} << off;
    split = |m8[7:4];
    row0  = cap_addr[ADDR_W-1:2];
    row1  = row0 + ROW_W'(1);
    case (off)
      2'd0:    wdata_rot = cap_wdata;
      2'd1:    wdata_rot = {cap_wdata[23:0], cap_wdata[31:24]};
      2'd2:    wdata_rot = {cap_wdata[15:0], cap_wdata[31:16]};
      default: wdata_rot = {cap_wdata[7:0],  cap_wdata[31:8]};
    endcase
  end

  // Read data assembly, evaluated in WT when the last row is on mem_rdata.
  // The two rows are concatenated, shifted down by the byte offset and the
  // bytes beyond the access size are cleared.
  always_comb begin
    rd64     = split ? {mem_rdata, lo_q} : {32'h0000_0000, mem_rdata};
    rd_shift = 32'(rd64 >> {off, 3'b000});
    case (cap_size)
      2'b00:   rd_final = {24'h00_0000, rd_shift[7:0]};
      2'b01:   rd_final = {16'h0000, rd_shift[15:0]};
      default: rd_final = rd_shift;
    endcase
  end

  // Next state and memory-side outputs. The memory is only driven in the
  // two beat states; everything else leaves the interface quiet.
  always_comb begin
    state_nx  = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_row   = '0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0000_0000;
    case (state)
      IDLE: begin
        if (if_gnt || dm_gnt) begin
          state_nx = B0;
        end
      end
      B0: begin
        mem_en    = 1'b1;
        mem_we    = cap_we;
        mem_row   = row0;
        mem_be    = m8[3:0];
        mem_wdata = wdata_rot;
        state_nx  = split ? B1 : WT;
      end
      B1: begin
        mem_en    = 1'b1;
        mem_we    = cap_we;
        mem_row   = row1;
        mem_be    = m8[7:4];
        mem_wdata = wdata_rot;
        state_nx  = WT;
      end
      WT: begin
        state_nx = RSP;
      end
      RSP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Response strobes come straight from the state; reset masks them so an
  // aborted access never signals completion.
  assign if_rvalid = (state == RSP) && !cap_dm && !rst;
  assign dm_rvalid = (state == RSP) &&  cap_dm && !rst;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  // State register, starvation counter, request capture and read-data
  // registers. Read data is written once, at the end of WT, and then held
  // so the port keeps its last value until the next load completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve     <= '0;
      cap_addr   <= '0;
      cap_we     <= 1'b0;
      cap_size   <= 2'b00;
      cap_dm     <= 1'b0;
      cap_wdata  <= 32'h0000_0000;
      lo_q       <= 32'h0000_0000;
      if_rdata_q <= 32'h0000_0000;
      dm_rdata_q <= 32'h0000_0000;
    end else begin
      state <= state_nx;

      if (state == IDLE) begin
        if (if_gnt) begin
          starve <= '0;
        end else if (if_req && !starved) begin
          starve <= starve + SW'(1);
        end
      end

      if (dm_gnt) begin
        cap_addr  <= dm_addr;
        cap_we    <= dm_we;
        cap_size  <= dm_size;
        cap_dm    <= 1'b1;
        cap_wdata <= dm_wdata;
      end else if (if_gnt) begin
        cap_addr  <= if_addr;
        cap_we    <= 1'b0;
        cap_size  <= 2'b10;
        cap_dm    <= 1'b0;
        cap_wdata <= 32'h0000_0000;
      end

      if (state == B1) begin
        lo_q <= mem_rdata;
      end

      if ((state == WT) && !cap_we) begin
        if (cap_dm) begin
          dm_rdata_q <= rd_final;
        end else begin
          if_rdata_q <= rd_final;
        end
      end
    end
  end

endmodule
